// File: rtl/frame_descrambler_pkg.sv
// frame_descrambler_pkg
//   Shared definitions for the frame descrambler and its LFSR datapath:
//   FSM state encoding, x^7+x^4+1 tap positions and the default LFSR seed.
package frame_descrambler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned TAP_HI       = 6;
    localparam int unsigned TAP_LO       = 3;
    localparam logic [6:0]  SEED_DEFAULT = 7'h7F;

endpackage

// File: rtl/frame_descrambler_scr_lfsr7.sv
// scr_lfsr7
//   7-bit shift register for the x^7+x^4+1 multiplicative (self-synchronising)
//   scrambler/descrambler. out = in ^ sr[TAP_HI] ^ sr[TAP_LO].
//   SCRAMBLE=0 (receive): the received bit `in` is shifted in.
//   SCRAMBLE=1 (transmit): the scrambled bit `out` is shifted in.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset, loads SEED
//   load  - reload SEED (start of frame)
//   shift - advance the register by one bit
//   in    - serial input bit
//   out   - combinational scrambled/descrambled bit
module scr_lfsr7
    import frame_descrambler_pkg::*;
#(
    parameter logic [6:0] SEED     = SEED_DEFAULT,
    parameter bit         SCRAMBLE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic shift,
    input  logic in,
    output logic out
);

    logic [6:0] sr;
    logic       fb;

    always_comb begin
        out = in ^ sr[TAP_HI] ^ sr[TAP_LO];
        fb  = SCRAMBLE ? out : in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= SEED;
        end else if (load) begin
            sr <= SEED;
        end else if (shift) begin
            sr <= {sr[5:0], fb};
        end
    end

endmodule

// File: rtl/frame_descrambler.sv
// frame_descrambler
//   Serial frame descrambler (x^7+x^4+1, multiplicative). A level request in
//   IDLE latches `length`, reloads the LFSR and receives `length` bits, one
//   per clock. Each descrambled bit appears registered on dataOut one cycle
//   after sampling, qualified by ready. done pulses one cycle after the last
//   ready.
//   Optional macro FRAME_DESCRAMBLER_BYTE_OUT_EN adds an LSB-first byte packer
//   (byteOut/byteValid); a final partial byte is zero-padded and emitted
//   together with done.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   request   - start-of-frame request (sampled in IDLE only)
//   length    - frame length in bits (latched at frame start)
//   dataIn    - scrambled serial input
//   dataOut   - registered descrambled bit (0 when ready is low)
//   ready     - dataOut holds a valid frame bit
//   busy      - frame reception in progress
//   done      - one-cycle frame completion pulse
//   byteOut   - packed byte (macro builds only)
//   byteValid - byteOut valid pulse (macro builds only)
module frame_descrambler
    import frame_descrambler_pkg::*;
#(
    parameter int unsigned LEN_W = 12,
    parameter logic [6:0]  SEED  = SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             request,
    input  logic [LEN_W-1:0] length,
    input  logic             dataIn,
    output logic             dataOut,
    output logic             ready,
    output logic             busy,
    output logic             done
`ifdef FRAME_DESCRAMBLER_BYTE_OUT_EN
    ,
    output logic [7:0]       byteOut,
    output logic             byteValid
`endif
);

    state_t           state, state_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic             load;
    logic             shift;
    logic             descr_bit;

    scr_lfsr7 #(
        .SEED     (SEED),
        .SCRAMBLE (1'b0)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .in    (dataIn),
        .out   (descr_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (length != '0) begin
                        state_n = RUN;
                        load    = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (cnt == len_q - LEN_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ready/dataOut trail the sampling cycle by one; done trails the DONE
    // state by one so it lands right after the final ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q   <= '0;
            cnt     <= '0;
            dataOut <= 1'b0;
            ready   <= 1'b0;
            done    <= 1'b0;
        end else begin
            ready   <= shift;
            dataOut <= shift & descr_bit;
            done    <= (state == DONE);
            if (load) begin
                len_q <= length;
                cnt   <= '0;
            end else if (shift) begin
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

`ifdef FRAME_DESCRAMBLER_BYTE_OUT_EN
    logic [7:0] acc, acc_n;
    logic [2:0] idx, idx_n;
    logic       emit;

    // The last frame bit is on dataOut during the DONE state, so it is
    // folded in before deciding whether a partial byte must be flushed.
    always_comb begin
        acc_n = acc;
        idx_n = idx;
        if (ready) begin
            acc_n[idx] = dataOut;
            idx_n      = idx + 3'd1;
        end
        emit = (ready && idx == 3'd7) || (state == DONE && idx_n != 3'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            idx       <= '0;
            byteOut   <= '0;
            byteValid <= 1'b0;
        end else begin
            byteValid <= emit;
            if (emit) begin
                byteOut <= acc_n;
                acc     <= '0;
                idx     <= '0;
            end else begin
                acc <= acc_n;
                idx <= idx_n;
            end
        end
    end
`else
    // byte packer not present in this build
`endif

endmodule
